tqvp_vga_capture: RTL and testbench
===================================

// Module: tqvp_vga_capture
// PURPOSE
// - TinyQV peripheral at the receiving end of a VGA link. It samples external hsync, vsync and
//   rrggbb inputs, which arrive pre-synchronised from ui_in.
// - Measures line period and lines per frame.
// - Captures one 256-sample 1-bit scanline into a CPU-readable buffer at 0x00-0x1C.
// - Raises an interrupt when a capture completes. Used to loop-back test VGA output peripherals.
// PARAMETERS
// - SAMPLE_COUNT  256  samples per capture, = 8 x 32-bit words
// - CNT_W         16   width of the per-line clock counter and of H_PERIOD
// PORTS
// - clk             in   1   system clock (64 MHz nominal)
// - rst             in   1   reset; synchronous, active-high
// - hsync_in        in   1   VGA hsync
// - vsync_in        in   1   VGA vsync
// - rgb_in          in   6   VGA rrggbb
// - address         in   6   register address
// - data_in         in   32  write data; low bits used per register
// - data_write_n    in   2   11 = none, else write (any width)
// - data_read_n     in   2   11 = none, else read
// - data_out        out  32  read data, combinational from address
// - data_ready      out  1   tied 1; reads and writes never stall
// - user_interrupt  out 1   done & irq_en
// BEHAVIOUR
// - Register map
//   - 0x00-0x1C  R   capture buffer; word n bit b = sample 32n+b
//   - 0x20  RW  CTRL: b0 arm (write-only, reads 0); b1 pol (1 = sync active-high); b2 irq_en
//   - 0x24  RW  CAP_Y[10:0]; 0 is treated as 1
//   - 0x28  RW  CAP_X[15:0]
//   - 0x2C  RW  CAP_STEP[7:0]; clocks per sample = CAP_STEP+1
//   - 0x30  RW  CAP_MASK[5:0]
//   - 0x34  R   H_PERIOD
//   - 0x38  R   V_LINES[10:0]
//   - 0x3C  R/W1C  STATUS: b0 done (W1C), b1 busy, b2 locked, b3 overrun (W1C)
//   - Unmapped addresses read 0.
// - Reset values: all registers 0, CAP_STEP = 3, CAP_MASK = 6'h3F; FSM IDLE; user_interrupt = 0.
//   Buffer contents are undefined after reset.
// - Edge detect
//   - hs = hsync_in ^ ~pol, and vs likewise.
//   - Leading edge = hs & ~hs_q, registered previous value; detected in the cycle the level changes.
// - h_cnt
//   - Reset to 0 on an hsync edge, else incremented, saturating at 2^CNT_W-1.
//   - On an hsync edge: H_PERIOD <= h_cnt+1 (saturating); locked <= (h_cnt+1 == H_PERIOD).
//   - If h_cnt saturates: H_PERIOD <= all-ones; locked <= 0.
// - vline
//   - Reset to 0 on a vsync edge; V_LINES <= vline in that same cycle.
//   - Incremented on an hsync edge without a simultaneous vsync edge (vsync wins).
//   - Saturates at 2047.
// - FSM
//   - IDLE -arm-> ARMED.
//   - ARMED -vsync edge-> WAIT_LINE.
//   - WAIT_LINE: on an hsync edge where vline post-update == CAP_Y, go to WAIT_X.
//   - WAIT_X: when h_cnt == CAP_X, take sample 0 and go to SAMPLING; step counter = 0.
//   - SAMPLING: sample k+1 taken CAP_STEP+1 clocks after sample k; after sample 255 -> DONE.
//   - DONE: set done, stay until the next arm.
//   - sample = |(rgb_in & CAP_MASK), written into buffer bit k in the same cycle.
// - busy = state in {ARMED, WAIT_LINE, WAIT_X, SAMPLING}.
// - Overrun
//   - An hsync edge in WAIT_X or SAMPLING, or a vsync edge in WAIT_LINE, means the line was missed.
//   - Action: go to DONE, set done and overrun; unwritten samples keep their old values.
// - Arm
//   - Arm in any state, including mid-capture, restarts at ARMED and clears done and overrun.
//   - Arm plus a W1C in the same write: the arm wins.
// - Reset mid-capture: returns to IDLE immediately; no interrupt.
// - Sampling latency: one clk from pin to buffer bit. A read in the same cycle as a buffer write
//   returns the old value.
// TESTING
// - Sync timing. Drive active-low syncs: hsync period 100 clocks (low 10), vsync every 20 lines.
//   Expected: after 2 frames H_PERIOD=100, V_LINES=20, locked=1.
// - Full capture. pol=0, CAP_Y=5, CAP_X=20, CAP_STEP=0; rgb_in toggles 6'h3F/6'h00 each clock,
//   starting 6'h3F at h_cnt=20. Expected: all 8 words = 32'h55555555; done=1.
//   With irq_en set, user_interrupt rises one clk after sample 255.
// - Mask and step. CAP_MASK=6'h03, CAP_STEP=3; rgb_in=6'h30 constant. Expected: all words 0.
//   Then rgb_in=6'h01: all words 32'hFFFFFFFF, last sample at h_cnt = CAP_X + 255*4.
// - Overrun. hsync period 200, CAP_X=100, CAP_STEP=0. Expected: hsync edge at sample 100,
//   DONE with overrun=1; words 4-7 unchanged from the prior capture.
// - Re-arm and W1C. Arm during SAMPLING: busy stays 1, done=0, capture restarts on the next
//   frame. Then write STATUS=1 after DONE: done=0, user_interrupt=0.
// - Reset and polarity. Assert rst mid-SAMPLING: state IDLE, STATUS=0, CAP_STEP reads 3.
//   Set pol=1 with inverted syncs: H_PERIOD and V_LINES match the active-low case.

Source files
------------

// File: rtl/tqvp_vga_capture.sv
// VGA loop-back capture peripheral: measures line period / lines per frame and grabs one 1-bit scanline.
// Latency: one clk pin-to-buffer; register reads are combinational; data_ready is tied high, never stalls.
module tqvp_vga_capture #(
    parameter int SAMPLE_COUNT = 256,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [5:0]  rgb_in,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int IDX_W = $clog2(SAMPLE_COUNT);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARMED     = 3'd1;
    localparam logic [2:0] S_WAIT_LINE = 3'd2;
    localparam logic [2:0] S_WAIT_X    = 3'd3;
    localparam logic [2:0] S_SAMPLING  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic                    r_pol, r_irq_en;
    logic [10:0]             r_cap_y;
    logic [CNT_W-1:0]        r_cap_x;
    logic [7:0]              r_cap_step;
    logic [5:0]              r_cap_mask;
    logic                    r_hs_q, r_vs_q;
    logic [CNT_W-1:0]        r_h_cnt, r_h_period;
    logic                    r_locked;
    logic [10:0]             r_vline, r_v_lines;
    logic [2:0]              r_state;
    logic [7:0]              r_step;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_done, r_ovr;
    logic [SAMPLE_COUNT-1:0] r_buf;

    logic             w_wr, w_arm, w_wr_status;
    logic             w_hs, w_vs, w_hs_edge, w_vs_edge;
    logic             w_h_max;
    logic [CNT_W-1:0] w_h_p1;
    logic [10:0]      w_vline_next, w_cap_y;
    logic             w_sample, w_take, w_ovr_evt, w_busy, w_last;
    logic             w_unused;

    assign w_wr        = (data_write_n != 2'b11);
    assign w_arm       = w_wr && (address == 6'h20) && data_in[0];
    assign w_wr_status = w_wr && (address == 6'h3C);

    assign w_hs      = hsync_in ^ ~r_pol;
    assign w_vs      = vsync_in ^ ~r_pol;
    assign w_hs_edge = w_hs & ~r_hs_q;
    assign w_vs_edge = w_vs & ~r_vs_q;

    assign w_h_max  = &r_h_cnt;
    assign w_h_p1   = w_h_max ? r_h_cnt : r_h_cnt + CNT_W'(1);
    assign w_cap_y  = (r_cap_y == 11'd0) ? 11'd1 : r_cap_y;
    assign w_sample = |(rgb_in & r_cap_mask);
    assign w_last   = (r_idx == IDX_W'(SAMPLE_COUNT - 1));
    assign w_busy   = r_state inside {S_ARMED, S_WAIT_LINE, S_WAIT_X, S_SAMPLING};

    assign data_ready     = 1'b1;
    assign user_interrupt = r_done & r_irq_en;
    assign w_unused       = ^{data_read_n, data_in};

    // vsync wins over a coincident hsync edge
    always_comb begin
        w_vline_next = r_vline;
        if (w_vs_edge)
            w_vline_next = 11'd0;
        else if (w_hs_edge && r_vline != 11'd2047)
            w_vline_next = r_vline + 11'd1;
    end

    // A missed sync edge aborts the capture and suppresses that cycle's sample
    always_comb begin
        w_take    = 1'b0;
        w_ovr_evt = 1'b0;
        case (r_state)
            S_WAIT_LINE: w_ovr_evt = w_vs_edge;
            S_WAIT_X: begin
                w_ovr_evt = w_hs_edge;
                w_take    = !w_hs_edge && (r_h_cnt == r_cap_x);
            end
            S_SAMPLING: begin
                w_ovr_evt = w_hs_edge;
                w_take    = !w_hs_edge && (r_step == r_cap_step);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_q     <= 1'b0;
            r_vs_q     <= 1'b0;
            r_h_cnt    <= '0;
            r_h_period <= '0;
            r_locked   <= 1'b0;
            r_vline    <= 11'd0;
            r_v_lines  <= 11'd0;
        end else begin
            r_hs_q  <= w_hs;
            r_vs_q  <= w_vs;
            r_vline <= w_vline_next;
            if (w_vs_edge)
                r_v_lines <= r_vline;
            if (w_hs_edge) begin
                r_h_cnt    <= '0;
                r_h_period <= w_h_p1;
                r_locked   <= (w_h_p1 == r_h_period);
            end else if (w_h_max) begin
                r_h_period <= '1;
                r_locked   <= 1'b0;
            end else begin
                r_h_cnt <= r_h_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pol      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_cap_y    <= 11'd0;
            r_cap_x    <= '0;
            r_cap_step <= 8'd3;
            r_cap_mask <= 6'h3F;
            r_state    <= S_IDLE;
            r_step     <= 8'd0;
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_wr) begin
                case (address)
                    6'h20: begin
                        r_pol    <= data_in[1];
                        r_irq_en <= data_in[2];
                    end
                    6'h24: r_cap_y    <= data_in[10:0];
                    6'h28: r_cap_x    <= data_in[CNT_W-1:0];
                    6'h2C: r_cap_step <= data_in[7:0];
                    6'h30: r_cap_mask <= data_in[5:0];
                    default: ;
                endcase
            end
            if (w_arm) begin
                r_state <= S_ARMED;
                r_done  <= 1'b0;
                r_ovr   <= 1'b0;
                r_idx   <= '0;
                r_step  <= 8'd0;
            end else begin
                if (w_wr_status && data_in[0]) r_done <= 1'b0;
                if (w_wr_status && data_in[3]) r_ovr  <= 1'b0;
                if (w_ovr_evt) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_ovr   <= 1'b1;
                end else begin
                    case (r_state)
                        S_ARMED:
                            if (w_vs_edge) r_state <= S_WAIT_LINE;
                        S_WAIT_LINE:
                            if (w_hs_edge && w_vline_next == w_cap_y) r_state <= S_WAIT_X;
                        S_WAIT_X:
                            if (w_take) begin
                                r_state <= S_SAMPLING;
                                r_step  <= 8'd0;
                                r_idx   <= r_idx + IDX_W'(1);
                            end
                        S_SAMPLING:
                            if (w_take) begin
                                r_step <= 8'd0;
                                r_idx  <= r_idx + IDX_W'(1);
                                if (w_last) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_step <= r_step + 8'd1;
                            end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Capture buffer has no reset; contents are only meaningful after a capture
    always_ff @(posedge clk) begin
        if (!rst && w_take)
            r_buf[r_idx] <= w_sample;
    end

    always_comb begin
        data_out = 32'd0;
        if (!address[5]) begin
            if (address[1:0] == 2'b00)
                data_out = r_buf[{address[4:2], 5'd0} +: 32];
        end else begin
            case (address)
                6'h20: data_out = {29'd0, r_irq_en, r_pol, 1'b0};
                6'h24: data_out = {21'd0, r_cap_y};
                6'h28: data_out = {{(32-CNT_W){1'b0}}, r_cap_x};
                6'h2C: data_out = {24'd0, r_cap_step};
                6'h30: data_out = {26'd0, r_cap_mask};
                6'h34: data_out = {{(32-CNT_W){1'b0}}, r_h_period};
                6'h38: data_out = {21'd0, r_v_lines};
                6'h3C: data_out = {28'd0, r_ovr, r_locked, w_busy, r_done};
                default: data_out = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_tqvp_vga_capture.sv
// Bench for tqvp_vga_capture: a sync/pixel generator plus a CPU bus driver.
// Expected buffer words are queued at arm time and drained once the capture signals done.
module tb_tqvp_vga_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        hsync_in, vsync_in;
    logic [5:0]  rgb_in;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n, data_read_n;
    logic [31:0] data_out;
    logic        data_ready, user_interrupt;

    tqvp_vga_capture dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Generator state; drv_* hold the position whose levels are currently on the pins
    int   g_period = 100, g_hlow = 10, g_vlines = 20, g_voff = 50;
    bit   g_pol = 1'b0, g_toggle = 1'b0;
    int   g_par = 1;
    logic [5:0] g_rgb = 6'h00;
    int   hpos = 0, line = 0, drv_hpos = 0, drv_line = 0;

    logic [5:0]  sb_addr_q[$];
    logic [31:0] sb_dat_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        rgb_in   = 6'h00;
        forever begin
            bit hs_act, vs_act;
            @(posedge clk);
            #1;
            hs_act   = hpos < g_hlow;
            vs_act   = (line == 0 && hpos >= g_voff) || (line == 1 && hpos < g_voff);
            hsync_in = g_pol ? hs_act : !hs_act;
            vsync_in = g_pol ? vs_act : !vs_act;
            rgb_in   = g_toggle ? (((hpos % 2) == g_par) ? 6'h3F : 6'h00) : g_rgb;
            drv_hpos = hpos;
            drv_line = line;
            hpos++;
            if (hpos >= g_period) begin
                hpos = 0;
                line = (line + 1 >= g_vlines) ? 0 : line + 1;
            end
        end
    end

    task automatic gen_set(input int period, input int vlines);
        @(negedge clk);
        g_period = period;
        g_vlines = vlines;
        hpos     = 0;
        line     = 0;
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        address      = a;
        data_in      = d;
        data_write_n = 2'b10;
        @(posedge clk);
        #2;
        data_write_n = 2'b11;
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [31:0] d);
        @(posedge clk);
        #2;
        address     = a;
        data_read_n = 2'b10;
        #1;
        d           = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (user_interrupt !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk({tag, " irq timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_pos(input int ln, input int hp, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(drv_line == ln && drv_hpos == hp) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("wait_pos timeout", 32'd0, 32'd1);
    endtask

    task automatic push_all(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            sb_addr_q.push_back(6'(i * 4));
            sb_dat_q.push_back(w);
        end
    endtask

    task automatic sb_drain(input string tag);
        logic [31:0] v;
        logic [5:0]  a;
        while (sb_addr_q.size() > 0) begin
            a = sb_addr_q.pop_front();
            cpu_read(a, v);
            chk($sformatf("%s word@%0h", tag, a), v, sb_dat_q.pop_front());
        end
    endtask

    task automatic cfg(input int y, input int x, input int step, input logic [5:0] mask);
        cpu_write(6'h24, 32'(y));
        cpu_write(6'h28, 32'(x));
        cpu_write(6'h2C, 32'(step));
        cpu_write(6'h30, {26'd0, mask});
    endtask

    initial begin
        logic [31:0] v;
        rst          = 1'b1;
        address      = 6'h00;
        data_in      = 32'd0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;

        cpu_read(6'h3C, v); chk("rst STATUS", v, 32'h0);
        cpu_read(6'h2C, v); chk("rst CAP_STEP", v, 32'h3);
        cpu_read(6'h30, v); chk("rst CAP_MASK", v, 32'h3F);
        cpu_read(6'h20, v); chk("rst CTRL", v, 32'h0);
        cpu_read(6'h22, v); chk("unmapped", v, 32'h0);
        chk("rst irq", {31'd0, user_interrupt}, 32'h0);
        chk("data_ready", {31'd0, data_ready}, 32'h1);

        // Sync timing, active-low, 100-clock lines, 20-line frames
        repeat (4500) @(posedge clk);
        cpu_read(6'h34, v); chk("H_PERIOD", v, 32'd100);
        cpu_read(6'h38, v); chk("V_LINES", v, 32'd20);
        cpu_read(6'h3C, v); chk("locked", v & 32'h4, 32'h4);

        // Full capture, alternating pixels starting with 3F at h_cnt 20
        gen_set(400, 8);
        g_toggle = 1'b1;
        g_par    = 1;
        cfg(5, 20, 0, 6'h3F);
        push_all(32'h55555555);
        cpu_write(6'h20, 32'h5);
        wait_irq("full", 10000);
        chk("full irq hpos", 32'(drv_hpos), 32'd277);
        chk("full irq line", 32'(drv_line), 32'd5);
        cpu_read(6'h3C, v); chk("full done", v & 32'hB, 32'h1);
        sb_drain("full");

        // Mask and step: masked-off bits give 0, then bit0 gives all ones
        gen_set(1100, 6);
        g_toggle = 1'b0;
        g_rgb    = 6'h30;
        cfg(1, 20, 3, 6'h03);
        push_all(32'h00000000);
        cpu_write(6'h20, 32'h5);
        wait_irq("mask0", 20000);
        chk("mask0 irq hpos", 32'(drv_hpos), 32'd1042);
        sb_drain("mask0");
        g_rgb = 6'h01;
        push_all(32'hFFFFFFFF);
        cpu_write(6'h20, 32'h5);
        wait_irq("mask1", 20000);
        chk("mask1 irq hpos", 32'(drv_hpos), 32'd1042);
        sb_drain("mask1");

        // Overrun: line ends mid-capture, upper words keep the previous all-ones
        gen_set(200, 6);
        g_rgb = 6'h00;
        cfg(1, 100, 0, 6'h03);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                sb_addr_q.push_back(6'(i * 4));
                sb_dat_q.push_back(i < 3 ? 32'h0 : 32'hFFFFFFFF);
            end
        end
        cpu_write(6'h20, 32'h5);
        wait_irq("ovr", 5000);
        cpu_read(6'h3C, v); chk("ovr STATUS", v & 32'hB, 32'h9);
        sb_drain("ovr");

        // Re-arm mid-sampling restarts the capture on the following frame
        gen_set(400, 8);
        g_toggle = 1'b1;
        g_par    = 1;
        cfg(5, 20, 0, 6'h03);
        cpu_write(6'h20, 32'h5);
        wait_pos(5, 150, 10000);
        cpu_write(6'h20, 32'h5);
        cpu_read(6'h3C, v); chk("rearm busy", v & 32'hB, 32'h2);
        repeat (200) @(posedge clk);
        cpu_read(6'h3C, v); chk("rearm still busy", v & 32'hB, 32'h2);
        push_all(32'h55555555);
        wait_irq("rearm", 10000);
        chk("rearm irq line", 32'(drv_line), 32'd5);
        sb_drain("rearm");
        cpu_write(6'h3C, 32'h1);
        cpu_read(6'h3C, v); chk("w1c done", v & 32'h1, 32'h0);
        @(negedge clk);
        chk("w1c irq", {31'd0, user_interrupt}, 32'h0);

        // Reset mid-sampling, then inverted-polarity sync measurement
        cpu_write(6'h20, 32'h5);
        wait_pos(5, 150, 10000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst irq mid", {31'd0, user_interrupt}, 32'h0);
        cpu_read(6'h3C, v); chk("rst mid STATUS", v, 32'h0);
        cpu_read(6'h2C, v); chk("rst mid CAP_STEP", v, 32'h3);
        g_toggle = 1'b0;
        cpu_write(6'h20, 32'h2);
        gen_set(100, 20);
        g_pol = 1'b1;
        repeat (5000) @(posedge clk);
        cpu_read(6'h34, v); chk("pol H_PERIOD", v, 32'd100);
        cpu_read(6'h38, v); chk("pol V_LINES", v, 32'd20);
        cpu_read(6'h3C, v); chk("pol locked", v & 32'h4, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
